// File: rtl/serialtopar_sync.sv
// Serial-to-parallel deserializer with comma-based word alignment.
// Shifts one bit per clk_8f edge, MSB first, hunts for COMMA at any bit
// offset, qualifies alignment with SYNC_COUNT aligned commas, then emits
// aligned data words (valid_par) and idle commas (comma_par) as strobes.
// Optional macro SERIALTOPAR_SYNC_LOS_EN: while locked, a comma seen at a
// misaligned offset drops lock and restarts the hunt.
module serialtopar_sync #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
  parameter int unsigned      SYNC_COUNT = 4
) (
  input  logic                     clk_8f,
  input  logic                     reset,
  input  logic                     in,
  output logic [WIDTH-1:0]         data_par,
  output logic                     valid_par,
  output logic                     comma_par,
  output logic                     locked,
  output logic [$clog2(WIDTH)-1:0] bit_ofs
);

  localparam int unsigned      OW          = $clog2(WIDTH);
  localparam logic [OW-1:0]    LAST_BIT    = OW'(WIDTH - 1);
  localparam logic [3:0]       SYNC_TARGET = 4'(SYNC_COUNT);

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    LOCKED
  } state_t;

  state_t           state, state_nxt;
  // Only WIDTH-1 history bits are stored: the oldest bit of the window is
  // never needed again once the next bit has been shifted in.
  logic [WIDTH-2:0] shreg;
  logic [WIDTH-1:0] window;
  logic [OW-1:0]    bit_cnt, bit_cnt_nxt;
  logic [3:0]       comma_cnt, comma_cnt_nxt;
  logic [3:0]       comma_cnt_inc;
  logic [WIDTH-1:0] data_nxt;
  logic             valid_nxt;
  logic             comma_nxt;
  logic             is_comma;
  logic             boundary;
  logic             lose_sync;

  assign window        = {shreg, in};
  assign is_comma      = (window == COMMA);
  assign comma_cnt_inc = comma_cnt + 4'd1;
  assign locked        = (state == LOCKED);
  assign bit_ofs       = bit_cnt;

  // Next-state, alignment counters and output strobe decode.
  always_comb begin
    state_nxt     = state;
    comma_cnt_nxt = comma_cnt;
    data_nxt      = data_par;
    valid_nxt     = 1'b0;
    comma_nxt     = 1'b0;
    lose_sync     = 1'b0;
    boundary      = (state == HUNT) ? is_comma : (bit_cnt == LAST_BIT);

    case (state)
      HUNT: begin
        if (is_comma) begin
          comma_cnt_nxt = 4'd1;
          state_nxt     = (SYNC_TARGET == 4'd1) ? LOCKED : SYNC;
        end
      end
      SYNC: begin
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_nxt = comma_cnt_inc;
            if (comma_cnt_inc == SYNC_TARGET) begin
              state_nxt = LOCKED;
            end
          end else begin
            state_nxt     = HUNT;
            comma_cnt_nxt = '0;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          if (is_comma) begin
            comma_nxt = 1'b1;
          end else begin
            data_nxt  = window;
            valid_nxt = 1'b1;
          end
        end
`ifdef SERIALTOPAR_SYNC_LOS_EN
        else if (is_comma) begin
          lose_sync     = 1'b1;
          state_nxt     = HUNT;
          comma_cnt_nxt = '0;
        end
`endif
      end
      default: begin
        state_nxt     = HUNT;
        comma_cnt_nxt = '0;
      end
    endcase

    if (boundary || lose_sync) begin
      bit_cnt_nxt = '0;
    end else if (bit_cnt == LAST_BIT) begin
      bit_cnt_nxt = '0;
    end else begin
      bit_cnt_nxt = bit_cnt + 1'b1;
    end
  end

  // State, shift register and registered output strobes.
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state     <= HUNT;
      shreg     <= '0;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      data_par  <= '0;
      valid_par <= 1'b0;
      comma_par <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= window[WIDTH-2:0];
      bit_cnt   <= bit_cnt_nxt;
      comma_cnt <= comma_cnt_nxt;
      data_par  <= data_nxt;
      valid_par <= valid_nxt;
      comma_par <= comma_nxt;
    end
  end

endmodule

// File: tb/tb_serialtopar_sync.sv
// Self-checking bench for serialtopar_sync: a default 8-bit instance and a
// 10-bit / single-comma-lock instance, checked bit by bit against a
// behavioural word-alignment model plus directed scenario checks.
module tb_serialtopar_sync;

`ifdef SERIALTOPAR_SYNC_LOS_EN
  localparam bit LOS = 1'b1;
`else
  localparam bit LOS = 1'b0;
`endif

  logic clk_8f = 1'b0;
  logic reset  = 1'b1;
  logic in8    = 1'b0;
  logic in10   = 1'b0;

  logic [7:0] data8;
  logic       valid8, comma8, locked8;
  logic [2:0] ofs8;
  logic [9:0] data10;
  logic       valid10, comma10, locked10;
  logic [3:0] ofs10;

  int n_cmp = 0;
  int n_bad = 0;

  // 5 ns half period bit clock.
  always #5 clk_8f = ~clk_8f;

  serialtopar_sync dut8 (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .in        (in8),
    .data_par  (data8),
    .valid_par (valid8),
    .comma_par (comma8),
    .locked    (locked8),
    .bit_ofs   (ofs8)
  );

  serialtopar_sync #(
    .WIDTH      (10),
    .COMMA      (10'h17C),
    .SYNC_COUNT (1)
  ) dut10 (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .in        (in10),
    .data_par  (data10),
    .valid_par (valid10),
    .comma_par (comma10),
    .locked    (locked10),
    .bit_ofs   (ofs10)
  );

  // Observed vector layouts: {data, valid, comma, locked, bit_ofs}
  logic [13:0] got8;
  logic [16:0] got10;
  assign got8  = {data8, valid8, comma8, locked8, ofs8};
  assign got10 = {data10, valid10, comma10, locked10, ofs10};

  // Reference model: mode 0 = hunting, 1 = qualifying, 2 = locked.
  typedef struct packed {
    logic [1:0]  mode;
    logic [3:0]  cnt;
    logic [3:0]  pos;
    logic [15:0] win;
    logic [15:0] data;
    logic        v;
    logic        c;
  } mstate_t;

  mstate_t m8  = '0;
  mstate_t m10 = '0;

  function automatic mstate_t mstep(mstate_t s, logic b, int w,
                                    int unsigned comma, int sc, bit los);
    mstate_t     n;
    int unsigned mask;
    int unsigned word;
    bit          hit;
    bit          aligned;
    bit          dropped;
    mask    = (32'd1 << w) - 32'd1;
    word    = ((32'(s.win) << 1) | 32'(b)) & mask;
    hit     = (word == comma);
    aligned = (s.mode == 2'd0) ? hit : (int'(s.pos) == w - 1);
    dropped = 1'b0;
    n       = s;
    n.v     = 1'b0;
    n.c     = 1'b0;
    n.win   = word[15:0];
    if (s.mode == 2'd0) begin
      if (hit) begin
        n.cnt  = 4'd1;
        n.mode = (sc == 1) ? 2'd2 : 2'd1;
      end
    end else if (s.mode == 2'd1) begin
      if (aligned) begin
        if (hit) begin
          n.cnt = s.cnt + 4'd1;
          if (int'(n.cnt) == sc) n.mode = 2'd2;
        end else begin
          n.mode = 2'd0;
          n.cnt  = 4'd0;
        end
      end
    end else begin
      if (aligned) begin
        if (hit) n.c = 1'b1;
        else begin
          n.data = word[15:0];
          n.v    = 1'b1;
        end
      end else if (los && hit) begin
        n.mode  = 2'd0;
        n.cnt   = 4'd0;
        dropped = 1'b1;
      end
    end
    if (aligned || dropped) n.pos = 4'd0;
    else n.pos = 4'((int'(s.pos) + 1) % w);
    return n;
  endfunction

  function automatic logic [13:0] exp8();
    return {m8.data[7:0], m8.v, m8.c, (m8.mode == 2'd2), m8.pos[2:0]};
  endfunction

  function automatic logic [16:0] exp10();
    return {m10.data[9:0], m10.v, m10.c, (m10.mode == 2'd2), m10.pos[3:0]};
  endfunction

  // Stimulus queues (bits for each instance, shared reset) and histories.
  logic bq[$];
  logic bq10[$];
  logic rq[$];
  logic [13:0] h8[$];
  logic [13:0] e8[$];
  logic [16:0] h10[$];
  logic [16:0] e10[$];

  task automatic add_word(input int sel, input logic [15:0] w, input int nb);
    for (int i = nb - 1; i >= 0; i--) begin
      if (sel == 0) begin
        bq.push_back(w[i]);
        rq.push_back(1'b0);
      end else begin
        bq10.push_back(w[i]);
      end
    end
  endtask

  task automatic add_reset();
    bq.push_back(1'b0);
    rq.push_back(1'b1);
  endtask

  task automatic tick(input logic b8, input logic b10, input logic r);
    reset = r;
    in8   = b8;
    in10  = b10;
    @(posedge clk_8f);
    #1;
    if (r) begin
      m8  = '0;
      m10 = '0;
    end else begin
      m8  = mstep(m8, b8, 8, 32'hBC, 4, LOS);
      m10 = mstep(m10, b10, 10, 32'h17C, 1, LOS);
    end
  endtask

  // Plays the queued stimulus, recording observed and modelled outputs.
  task automatic drive_all();
    int n;
    n = (bq.size() > bq10.size()) ? bq.size() : bq10.size();
    h8.delete();  e8.delete();
    h10.delete(); e10.delete();
    for (int i = 0; i < n; i++) begin
      tick((i < bq.size())   ? bq[i]   : 1'b0,
           (i < bq10.size()) ? bq10[i] : 1'b0,
           (i < rq.size())   ? rq[i]   : 1'b0);
      h8.push_back(got8);
      e8.push_back(exp8());
      h10.push_back(got10);
      e10.push_back(exp10());
    end
    bq.delete(); bq10.delete(); rq.delete();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    add_reset();
    add_word(0, 16'h1, 1);
    bq[0] = 1'b1;
    rq[1] = 1'b1;
    drive_all();
    n_cmp++;
    if (h8[0] !== 14'h0) begin
      n_bad++; $display("FAIL reset8 got %h expected %h", h8[0], 14'h0);
    end
    n_cmp++;
    if (h10[1] !== 17'h0) begin
      n_bad++; $display("FAIL reset10 got %h expected %h", h10[1], 17'h0);
    end
    foreach (h8[i]) begin
      n_cmp++;
      if (h8[i] !== e8[i]) begin
        n_bad++; $display("FAIL reset_model bit %0d got %h expected %h", i, h8[i], e8[i]);
      end
    end
  endtask

  task automatic test_lock_offset();
    add_reset();
    add_word(0, 16'h0, 3);
    add_word(0, 16'h00, 8);
    repeat (4) add_word(0, 16'hBC, 8);
    add_word(0, 16'h5A, 8);
    drive_all();
    foreach (h8[i]) begin
      n_cmp++;
      if (h8[i] !== e8[i]) begin
        n_bad++; $display("FAIL lock_offset bit %0d got %h expected %h", i, h8[i], e8[i]);
      end
    end
    n_cmp++;
    if (h8[42][3] !== 1'b0) begin
      n_bad++; $display("FAIL lock_early got %b expected 0", h8[42][3]);
    end
    n_cmp++;
    if (h8[43][3] !== 1'b1 || h8[43][4] !== 1'b0) begin
      n_bad++; $display("FAIL lock_rise locked/comma got %b%b expected 10", h8[43][3], h8[43][4]);
    end
    n_cmp++;
    if (h8[50][5] !== 1'b0) begin
      n_bad++; $display("FAIL first_valid_early got %b expected 0", h8[50][5]);
    end
    n_cmp++;
    if (h8[51][5] !== 1'b1 || h8[51][13:6] !== 8'h5A) begin
      n_bad++; $display("FAIL first_word valid/data got %b/%h expected 1/5a", h8[51][5], h8[51][13:6]);
    end
  endtask

  task automatic test_strobes();
    add_word(0, 16'hBC, 8);
    add_word(0, 16'h12, 8);
    add_word(0, 16'hBC, 8);
    drive_all();
    foreach (h8[i]) begin
      n_cmp++;
      if (h8[i] !== e8[i]) begin
        n_bad++; $display("FAIL strobes bit %0d got %h expected %h", i, h8[i], e8[i]);
      end
    end
    n_cmp++;
    if (h8[0][5] !== 1'b0 || h8[0][13:6] !== 8'h5A) begin
      n_bad++; $display("FAIL valid_width got %b/%h expected 0/5a", h8[0][5], h8[0][13:6]);
    end
    n_cmp++;
    if (h8[7][4] !== 1'b1 || h8[8][4] !== 1'b0) begin
      n_bad++; $display("FAIL idle_comma got %b%b expected 10", h8[7][4], h8[8][4]);
    end
    n_cmp++;
    if (h8[15][5] !== 1'b1 || h8[15][13:6] !== 8'h12) begin
      n_bad++; $display("FAIL data_12 got %b/%h expected 1/12", h8[15][5], h8[15][13:6]);
    end
    n_cmp++;
    if (h8[23][4] !== 1'b1 || h8[23][5] !== 1'b0 || h8[23][13:6] !== 8'h12) begin
      n_bad++; $display("FAIL comma_hold got %b%b/%h expected 10/12", h8[23][4], h8[23][5], h8[23][13:6]);
    end
  endtask

  task automatic test_sync_fail();
    int early_valid;
    add_reset();
    repeat (2) add_word(0, 16'hBC, 8);
    add_word(0, 16'h33, 8);
    repeat (4) add_word(0, 16'hBC, 8);
    add_word(0, 16'h77, 8);
    drive_all();
    early_valid = 0;
    foreach (h8[i]) begin
      n_cmp++;
      if (h8[i] !== e8[i]) begin
        n_bad++; $display("FAIL sync_fail bit %0d got %h expected %h", i, h8[i], e8[i]);
      end
      if (i <= 56 && (h8[i][5] || h8[i][4])) early_valid++;
    end
    n_cmp++;
    if (early_valid != 0) begin
      n_bad++; $display("FAIL sync_fail_strobes got %0d expected 0", early_valid);
    end
    n_cmp++;
    if (h8[55][3] !== 1'b0 || h8[56][3] !== 1'b1) begin
      n_bad++; $display("FAIL relock got %b%b expected 01", h8[55][3], h8[56][3]);
    end
    n_cmp++;
    if (h8[64][5] !== 1'b1 || h8[64][13:6] !== 8'h77) begin
      n_bad++; $display("FAIL after_relock got %b/%h expected 1/77", h8[64][5], h8[64][13:6]);
    end
  endtask

  task automatic test_reset_mid();
    add_word(0, 16'hA, 4);
    add_reset();
    repeat (4) add_word(0, 16'hBC, 8);
    drive_all();
    foreach (h8[i]) begin
      n_cmp++;
      if (h8[i] !== e8[i]) begin
        n_bad++; $display("FAIL reset_mid bit %0d got %h expected %h", i, h8[i], e8[i]);
      end
    end
    n_cmp++;
    if (h8[4] !== 14'h0) begin
      n_bad++; $display("FAIL reset_mid_clear got %h expected %h", h8[4], 14'h0);
    end
    n_cmp++;
    if (h8[28][3] !== 1'b0 || h8[36][3] !== 1'b1) begin
      n_bad++; $display("FAIL reset_mid_relock got %b%b expected 01", h8[28][3], h8[36][3]);
    end
  endtask

  task automatic test_misaligned();
    add_reset();
    repeat (4) add_word(0, 16'hBC, 8);
    add_word(0, 16'h11, 8);
    add_word(0, 16'h0, 3);
    add_word(0, 16'hBC, 8);
    add_word(0, 16'h5A, 8);
    add_word(0, 16'h3C, 8);
    drive_all();
    foreach (h8[i]) begin
      n_cmp++;
      if (h8[i] !== e8[i]) begin
        n_bad++; $display("FAIL misaligned bit %0d got %h expected %h", i, h8[i], e8[i]);
      end
    end
    n_cmp++;
    if (h8[40][5] !== 1'b1 || h8[40][13:6] !== 8'h11) begin
      n_bad++; $display("FAIL pre_slip got %b/%h expected 1/11", h8[40][5], h8[40][13:6]);
    end
`ifdef SERIALTOPAR_SYNC_LOS_EN
    n_cmp++;
    if (h8[50][3] !== 1'b1 || h8[51][3] !== 1'b0) begin
      n_bad++; $display("FAIL los_drop got %b%b expected 10", h8[50][3], h8[51][3]);
    end
    n_cmp++;
    if (h8[51][5] !== 1'b0 || h8[51][4] !== 1'b0 || h8[51][2:0] !== 3'd0) begin
      n_bad++; $display("FAIL los_quiet got %h expected strobes 0 ofs 0", h8[51]);
    end
`else
    n_cmp++;
    if (h8[67][3] !== 1'b1) begin
      n_bad++; $display("FAIL stay_locked got %b expected 1", h8[67][3]);
    end
    n_cmp++;
    if (h8[48][5] !== 1'b1 || h8[48][13:6] !== 8'h17) begin
      n_bad++; $display("FAIL shifted_a got %b/%h expected 1/17", h8[48][5], h8[48][13:6]);
    end
    n_cmp++;
    if (h8[56][5] !== 1'b1 || h8[56][13:6] !== 8'h8B) begin
      n_bad++; $display("FAIL shifted_b got %b/%h expected 1/8b", h8[56][5], h8[56][13:6]);
    end
    n_cmp++;
    if (h8[64][5] !== 1'b1 || h8[64][13:6] !== 8'h47) begin
      n_bad++; $display("FAIL shifted_c got %b/%h expected 1/47", h8[64][5], h8[64][13:6]);
    end
`endif
  endtask

  task automatic test_width10();
    add_reset();
    bq10.push_back(1'b0);
    add_word(1, 16'h17C, 10);
    add_word(1, 16'h2AA, 10);
    add_word(1, 16'h17C, 10);
    add_word(1, 16'h155, 10);
    drive_all();
    foreach (h10[i]) begin
      n_cmp++;
      if (h10[i] !== e10[i]) begin
        n_bad++; $display("FAIL width10 bit %0d got %h expected %h", i, h10[i], e10[i]);
      end
    end
    n_cmp++;
    if (h10[9][4] !== 1'b0 || h10[10][4] !== 1'b1 || h10[10][5] !== 1'b0) begin
      n_bad++; $display("FAIL w10_lock got %b%b%b expected 010", h10[9][4], h10[10][4], h10[10][5]);
    end
    n_cmp++;
    if (h10[20][6] !== 1'b1 || h10[20][16:7] !== 10'h2AA) begin
      n_bad++; $display("FAIL w10_data got %b/%h expected 1/2aa", h10[20][6], h10[20][16:7]);
    end
    n_cmp++;
    if (h10[30][5] !== 1'b1 || h10[40][6] !== 1'b1 || h10[40][16:7] !== 10'h155) begin
      n_bad++; $display("FAIL w10_seq got %b %b/%h expected 1 1/155", h10[30][5], h10[40][6], h10[40][16:7]);
    end
  endtask

  task automatic test_random();
    int r;
    int both;
    add_reset();
    repeat (4) add_word(0, 16'hBC, 8);
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        add_reset();
        repeat (4) add_word(0, 16'hBC, 8);
      end else if (r < 12) begin
        add_word(0, 16'($urandom), $urandom_range(1, 7));
      end else if (r < 40) begin
        add_word(0, 16'hBC, 8);
      end else begin
        add_word(0, 16'($urandom), 8);
      end
    end
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 1) == 0) add_word(1, 16'h17C, 10);
      else add_word(1, 16'($urandom), $urandom_range(3, 10));
    end
    drive_all();
    both = 0;
    foreach (h8[i]) begin
      n_cmp++;
      if (h8[i] !== e8[i]) begin
        n_bad++; $display("FAIL random8 bit %0d got %h expected %h", i, h8[i], e8[i]);
      end
      n_cmp++;
      if (h10[i] !== e10[i]) begin
        n_bad++; $display("FAIL random10 bit %0d got %h expected %h", i, h10[i], e10[i]);
      end
      if ((h8[i][5] && h8[i][4]) || (h10[i][6] && h10[i][5])) both++;
    end
    n_cmp++;
    if (both != 0) begin
      n_bad++; $display("FAIL strobe_exclusive got %0d overlaps expected 0", both);
    end
  endtask

  initial begin
    test_reset();
    test_lock_offset();
    test_strobes();
    test_sync_fail();
    test_reset_mid();
    test_misaligned();
    test_width10();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
